lcd_box_overlay: RTL and testbench

- Downstream stage of the LCD timing controller. Consumes its registered HD/VD/DEN and 8-bit RGB stream, and draws a rectangular border around the motion-detection bounding box.
- Rebuilds pixel column and row from the sync/enable stream. Box coordinates are double-buffered so that they change only on frame boundaries.
- Forwards the stream to the LTM pins with a fixed 1-cycle latency.

---
 rtl/lcd_box_overlay.sv | 135 +++++++++++++
 tb/tb_lcd_box_overlay.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lcd_box_overlay.sv
// Registered pass-through of the LCD stream that paints a bounding-box border.
// Optional LCD_BOX_CROSSHAIR_EN adds a 1-pixel centre crosshair inside the box.
module lcd_box_overlay #(
  parameter int          H_ACT     = 800,
  parameter int          V_ACT     = 480,
  parameter int          BORDER    = 2,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iHD,
  input  logic        iVD,
  input  logic        iDEN,
  input  logic [7:0]  iLCD_R,
  input  logic [7:0]  iLCD_G,
  input  logic [7:0]  iLCD_B,
  input  logic [10:0] iBOX_X0,
  input  logic [10:0] iBOX_X1,
  input  logic [9:0]  iBOX_Y0,
  input  logic [9:0]  iBOX_Y1,
  input  logic        iBOX_VALID,
  output logic        oHD,
  output logic        oVD,
  output logic        oDEN,
  output logic [7:0]  oLCD_R,
  output logic [7:0]  oLCD_G,
  output logic [7:0]  oLCD_B,
  output logic        oBOX_ACTIVE
);
  localparam logic [11:0] HA  = 12'(H_ACT);
  localparam logic [11:0] VA  = 12'(V_ACT);
  localparam logic [11:0] BW  = 12'(BORDER);
  localparam logic [10:0] XMX = 11'(H_ACT - 1);
  localparam logic [9:0]  YMX = 10'(V_ACT - 1);

  typedef struct packed {
    logic        vld;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [9:0]  y0;
    logic [9:0]  y1;
  } box_t;

  box_t        sh, sh_nxt;
  logic [10:0] col;
  logic [9:0]  row;
  logic        vd_fall, den_fall;
  logic        hit;

  // oVD/oDEN are exactly last cycle's iVD/iDEN, so they double as edge history.
  assign vd_fall  = !iVD  && oVD;
  assign den_fall = !iDEN && oDEN;

  always_comb begin
    sh_nxt     = '0;
    sh_nxt.vld = iBOX_VALID && (iBOX_X0 <= iBOX_X1) && (iBOX_Y0 <= iBOX_Y1) &&
                 ({1'b0, iBOX_X0} < HA) && ({2'b0, iBOX_Y0} < VA);
    sh_nxt.x0  = iBOX_X0;
    sh_nxt.y0  = iBOX_Y0;
    sh_nxt.x1  = (iBOX_X1 > XMX) ? XMX : iBOX_X1;
    sh_nxt.y1  = (iBOX_Y1 > YMX) ? YMX : iBOX_Y1;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      col <= '0;
      row <= '0;
      sh  <= '0;
    end else begin
      if (iDEN) col <= (col == 11'h7FF) ? col : col + 11'd1;
      else      col <= '0;
      if (!iVD)          row <= '0;
      else if (den_fall) row <= (row == 10'h3FF) ? row : row + 10'd1;
      if (vd_fall) sh <= sh_nxt;
    end
  end

`ifdef LCD_BOX_CROSSHAIR_EN
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [11:0] cx_sum, cy_sum;

  assign cx_sum = {1'b0, sh_nxt.x0} + {1'b0, sh_nxt.x1};
  assign cy_sum = {2'b0, sh_nxt.y0} + {2'b0, sh_nxt.y1};

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cx <= '0;
      cy <= '0;
    end else if (vd_fall) begin
      cx <= cx_sum[11:1];
      cy <= cy_sum[10:1];
    end
  end
`endif

  always_comb begin
    logic [11:0] c, r, x0, x1, y0, y1;
    logic        in_box, on_edge, xh;
    c  = {1'b0, col};
    r  = {2'b0, row};
    x0 = {1'b0, sh.x0};
    x1 = {1'b0, sh.x1};
    y0 = {2'b0, sh.y0};
    y1 = {2'b0, sh.y1};
    in_box  = (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1);
    // A box narrower than twice the border satisfies an edge term everywhere -> solid fill.
    on_edge = (c < x0 + BW) || (c + BW > x1) || (r < y0 + BW) || (r + BW > y1);
`ifdef LCD_BOX_CROSSHAIR_EN
    xh = (col == cx) || (row == cy);
`else
    xh = 1'b0;
`endif
    hit = iDEN && sh.vld && in_box && (on_edge || xh);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oHD         <= 1'b0;
      oVD         <= 1'b0;
      oDEN        <= 1'b0;
      oLCD_R      <= '0;
      oLCD_G      <= '0;
      oLCD_B      <= '0;
      oBOX_ACTIVE <= 1'b0;
    end else begin
      oHD         <= iHD;
      oVD         <= iVD;
      oDEN        <= iDEN;
      oBOX_ACTIVE <= hit;
      if (hit) {oLCD_R, oLCD_G, oLCD_B} <= BOX_COLOR;
      else     {oLCD_R, oLCD_G, oLCD_B} <= {iLCD_R, iLCD_G, iLCD_B};
    end
  end
endmodule

// File: tb/tb_lcd_box_overlay.sv
// Randomised/directed bench for lcd_box_overlay on a reduced 48x32 raster.
module tb_lcd_box_overlay;
  localparam int H  = 48;
  localparam int V  = 32;
  localparam int B  = 2;
  localparam int HB = 6;
  localparam int LT = HB + H;
  localparam int FL = V + 2;
  localparam logic [23:0] COL = 24'hFF0000;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iHD, iVD, iDEN;
  logic [7:0]  iLCD_R, iLCD_G, iLCD_B;
  logic [10:0] iBOX_X0, iBOX_X1;
  logic [9:0]  iBOX_Y0, iBOX_Y1;
  logic        iBOX_VALID;
  logic        oHD, oVD, oDEN;
  logic [7:0]  oLCD_R, oLCD_G, oLCD_B;
  logic        oBOX_ACTIVE;

  lcd_box_overlay #(.H_ACT(H), .V_ACT(V), .BORDER(B), .BOX_COLOR(COL)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iHD(iHD), .iVD(iVD), .iDEN(iDEN),
    .iLCD_R(iLCD_R), .iLCD_G(iLCD_G), .iLCD_B(iLCD_B),
    .iBOX_X0(iBOX_X0), .iBOX_X1(iBOX_X1), .iBOX_Y0(iBOX_Y0), .iBOX_Y1(iBOX_Y1),
    .iBOX_VALID(iBOX_VALID),
    .oHD(oHD), .oVD(oVD), .oDEN(oDEN),
    .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B), .oBOX_ACTIVE(oBOX_ACTIVE)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int nact;
  // Reference model: box latched at the frame start, pixel position known from the raster loops.
  bit m_pvd;
  bit m_vld;
  int m_x0, m_x1, m_y0, m_y1, m_cx, m_cy;

  task automatic set_box(input int x0, input int x1, input int y0, input int y1, input bit v);
    iBOX_X0 = 11'(x0); iBOX_X1 = 11'(x1);
    iBOX_Y0 = 10'(y0); iBOX_Y1 = 10'(y1);
    iBOX_VALID = v;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit hd, input bit vd, input bit den, input int x, input int y,
                     input logic [23:0] rgb);
    logic [27:0] exp, obs;
    bit hit;
    iHD = hd; iVD = vd; iDEN = den;
    {iLCD_R, iLCD_G, iLCD_B} = rgb;
    hit = iRST_n && den && m_vld && x >= m_x0 && x <= m_x1 && y >= m_y0 && y <= m_y1 &&
          (x < m_x0 + B || x + B > m_x1 || y < m_y0 + B || y + B > m_y1
`ifdef LCD_BOX_CROSSHAIR_EN
           || x == m_cx || y == m_cy
`endif
          );
    exp = iRST_n ? {hd, vd, den, (hit ? COL : rgb), hit} : 28'd0;
    if (!iRST_n) begin
      m_pvd = 1'b0; m_vld = 1'b0;
    end else begin
      if (!vd && m_pvd) begin
        m_vld = iBOX_VALID && iBOX_X0 <= iBOX_X1 && iBOX_Y0 <= iBOX_Y1 &&
                int'(iBOX_X0) < H && int'(iBOX_Y0) < V;
        m_x0 = int'(iBOX_X0);
        m_y0 = int'(iBOX_Y0);
        m_x1 = (int'(iBOX_X1) > H - 1) ? H - 1 : int'(iBOX_X1);
        m_y1 = (int'(iBOX_Y1) > V - 1) ? V - 1 : int'(iBOX_Y1);
        m_cx = (m_x0 + m_x1) / 2;
        m_cy = (m_y0 + m_y1) / 2;
      end
      m_pvd = vd;
    end
    @(posedge iCLK); #1;
    obs = {oHD, oVD, oDEN, oLCD_R, oLCD_G, oLCD_B, oBOX_ACTIVE};
    if (oBOX_ACTIVE) nact++;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL pix x=%0d y=%0d obs=%h exp=%h", x, y, obs, exp);
    end
  endtask

  // Raster: line 0 has VD low, line 1 is blank, lines 2.. are active. HD low on cycle 0.
  // chg_line >= 0 applies the nb_* box at the start of that line (mid-frame update).
  int nb_x0, nb_x1, nb_y0, nb_y1;
  bit nb_v;
  task automatic run_frame(input int start_line, input int chg_line, input bit rnd);
    nact = 0;
    for (int l = start_line; l < FL; l++) begin
      if (l == chg_line) set_box(nb_x0, nb_x1, nb_y0, nb_y1, nb_v);
      for (int c = 0; c < LT; c++) begin
        bit act;
        logic [23:0] px;
        act = (l >= 2) && (c >= HB);
        px  = rnd ? 24'($urandom) : 24'h808080;
        cyc(c != 0, l != 0, act, c - HB, l - 2, act ? px : 24'h0);
      end
    end
  endtask

  initial begin
    iRST_n = 1'b0;
    m_pvd = 1'b0; m_vld = 1'b0;
    m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_cx = 0; m_cy = 0;
    nact = 0;
    set_box(10, 29, 5, 24, 1'b1);
    // Reset held while stimulus toggles
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 24'($urandom));
    // Release mid-frame with a valid box: pass-through only until the next VD fall
    iRST_n = 1'b1;
    run_frame(10, -1, 1'b1);
    check_int("post_reset_no_border", nact, 0);
    // Basic box 20x20, border 2
    run_frame(0, -1, 1'b0);
    check_int("basic_count", nact, 20 * 20 - 16 * 16);
    // Mid-frame change to full screen at row 10: current frame unchanged
    nb_x0 = 0; nb_x1 = H - 1; nb_y0 = 0; nb_y1 = V - 1; nb_v = 1'b1;
    run_frame(0, 12, 1'b1);
    check_int("midframe_count", nact, 20 * 20 - 16 * 16);
    run_frame(0, -1, 1'b0);
    check_int("full_count", nact, H * V - (H - 4) * (V - 4));
    // Invalid cases
    set_box(30, 10, 5, 24, 1'b1);
    run_frame(0, -1, 1'b0);
    check_int("x0_gt_x1", nact, 0);
    set_box(10, 29, 5, 24, 1'b0);
    run_frame(0, -1, 1'b1);
    check_int("valid_low", nact, 0);
    // X1 clamp: box (40..47)x(0..9) after clamp
    set_box(40, 2000, 0, 9, 1'b1);
    run_frame(0, -1, 1'b0);
    check_int("clamp_count", nact, 8 * 10 - 4 * 6);
    // Tiny box is solid
    set_box(10, 12, 10, 12, 1'b1);
    run_frame(0, -1, 1'b0);
    check_int("solid_count", nact, 9);
    // Random boxes, some with mid-frame changes
    for (int f = 0; f < 8; f++) begin
      set_box($urandom_range(0, 60), $urandom_range(0, 60),
              $urandom_range(0, 40), $urandom_range(0, 40), 1'($urandom_range(0, 3) != 0));
      nb_x0 = $urandom_range(0, 50); nb_x1 = $urandom_range(0, 2047);
      nb_y0 = $urandom_range(0, 35); nb_y1 = $urandom_range(0, 1023);
      nb_v  = 1'b1;
      run_frame(0, $urandom_range(1, FL - 1), 1'b1);
    end
    run_frame(0, -1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
